// File: rtl/ysyx_22050243_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states and grant-owner encoding.
package ysyx_22050243_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

endpackage

// File: rtl/ysyx_22050243_arb_pick.sv
// Winner selection between fetch and data requesters.
// YSYX_22050243_ARB_RR_EN selects round-robin; otherwise data has fixed priority over fetch.
module ysyx_22050243_arb_pick
  import ysyx_22050243_arb_pkg::*;
(
`ifdef YSYX_22050243_ARB_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic i_update,
`endif
  input  logic i_req_i,
  input  logic i_req_d,
  output logic o_valid,
  output gnt_t o_gnt
);

`ifdef YSYX_22050243_ARB_RR_EN
  gnt_t r_last;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_last <= GNT_I;
    else if (i_update) r_last <= o_gnt;
  end

  // NOTE: o_gnt gets a default first so no path through this block can infer a latch.
  always_comb begin
    o_gnt = GNT_D;
    if (i_req_i && i_req_d) o_gnt = (r_last == GNT_D) ? GNT_I : GNT_D;
    else if (i_req_i)       o_gnt = GNT_I;
  end
`else
  always_comb begin
    o_gnt = i_req_d ? GNT_D : GNT_I;
  end
`endif

  assign o_valid = i_req_i | i_req_d;

endmodule

// File: rtl/ysyx_22050243_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and data access.
// Define YSYX_22050243_ARB_RR_EN for round-robin arbitration (default: data-over-fetch priority).
module ysyx_22050243_mem_arbiter
  import ysyx_22050243_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int DDATA_WIDTH = 64,
  parameter int IDATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_req,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  output logic                   i_rvalid,
  output logic [IDATA_WIDTH-1:0] i_rdata,
  input  logic                   d_rd,
  input  logic                   d_wr,
  input  logic [ADDR_WIDTH-1:0]  d_addr,
  input  logic [DDATA_WIDTH-1:0] d_wdata,
  input  logic [7:0]             d_wmask,
  output logic                   d_rvalid,
  output logic [DDATA_WIDTH-1:0] d_rdata,
  output logic                   d_wready,
  output logic                   m_req,
  output logic                   m_we,
  output logic [ADDR_WIDTH-1:0]  m_addr,
  output logic [DDATA_WIDTH-1:0] m_wdata,
  output logic [7:0]             m_wmask,
  input  logic                   m_gnt,
  input  logic                   m_rvalid,
  input  logic [DDATA_WIDTH-1:0] m_rdata
);

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  gnt_t                   r_owner;
  gnt_t                   w_gnt;
  logic                   w_valid;
  logic                   w_rsp_busy;
  logic                   w_accept;
  logic                   r_m_we;
  logic [ADDR_WIDTH-1:0]  r_m_addr;
  logic [DDATA_WIDTH-1:0] r_m_wdata;
  logic [7:0]             r_m_wmask;
  logic                   r_i_rvalid;
  logic [IDATA_WIDTH-1:0] r_i_rdata;
  logic [IDATA_WIDTH-1:0] w_fetch_word;
  logic                   r_d_rvalid;
  logic [DDATA_WIDTH-1:0] r_d_rdata;
  logic                   r_d_wready;

  ysyx_22050243_arb_pick u_pick (
`ifdef YSYX_22050243_ARB_RR_EN
    .clk      (clk),
    .rst      (rst),
    .i_update (w_accept),
`endif
    .i_req_i  (i_req),
    .i_req_d  (d_rd | d_wr),
    .o_valid  (w_valid),
    .o_gnt    (w_gnt)
  );

  // The IDLE cycle carrying the previous response pulse does not sample, which
  // guarantees a quiet IDLE cycle between transactions.
  assign w_rsp_busy = r_i_rvalid | r_d_rvalid | r_d_wready;
  assign w_accept   = (r_state == IDLE) && w_valid && !w_rsp_busy;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = REQ;
      REQ:     if (m_gnt)    w_state_nxt = r_m_we ? IDLE : WAIT;
      WAIT:    if (m_rvalid) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_fetch_word = r_m_addr[2] ? m_rdata[2*IDATA_WIDTH-1:IDATA_WIDTH]
                               : m_rdata[IDATA_WIDTH-1:0];
  end

  // NOTE: every output register, read data included, is reset so nothing leaks out after an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner    <= GNT_I;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_m_wmask  <= '0;
      r_i_rvalid <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rvalid <= 1'b0;
      r_d_rdata  <= '0;
      r_d_wready <= 1'b0;
    end else begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_d_wready <= 1'b0;

      if (w_accept) begin
        r_owner <= w_gnt;
        if (w_gnt == GNT_D) begin
          r_m_we    <= d_wr;
          r_m_addr  <= d_addr;
          r_m_wdata <= d_wr ? d_wdata : '0;
          r_m_wmask <= d_wr ? d_wmask : '0;
        end else begin
          r_m_we    <= 1'b0;
          r_m_addr  <= i_addr;
          r_m_wdata <= '0;
          r_m_wmask <= '0;
        end
      end

      if (r_state == REQ && m_gnt && r_m_we) r_d_wready <= 1'b1;

      if (r_state == WAIT && m_rvalid) begin
        if (r_owner == GNT_I) begin
          r_i_rvalid <= 1'b1;
          r_i_rdata  <= w_fetch_word;
        end else begin
          r_d_rvalid <= 1'b1;
          r_d_rdata  <= m_rdata;
        end
      end
    end
  end

  assign m_req    = (r_state == REQ);
  assign m_we     = r_m_we;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign m_wmask  = r_m_wmask;
  assign i_rvalid = r_i_rvalid;
  assign i_rdata  = r_i_rdata;
  assign d_rvalid = r_d_rvalid;
  assign d_rdata  = r_d_rdata;
  assign d_wready = r_d_wready;

endmodule

// File: doc/ysyx_22050243_mem_arbiter.md
YSYX_22050243_MEM_ARBITER -- requirements
Module: ysyx_22050243_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, memory address width.
REQ-002 SHALL have parameter DDATA_WIDTH, default 64, data-bus and memory data width.
REQ-003 SHALL have parameter IDATA_WIDTH, default 32, instruction width.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports i_req  input  1  fetch request; i_addr  input  ADDR_WIDTH  fetch address.
REQ-007 SHALL have ports i_rvalid  output  1  fetch response pulse; i_rdata  output  IDATA_WIDTH  fetched word.
REQ-008 SHALL have ports d_rd  input  1  load request; d_wr  input  1  store request; d_addr  input  ADDR_WIDTH  data address.
REQ-009 SHALL have ports d_wdata  input  DDATA_WIDTH  store data; d_wmask  input  8  byte mask.
REQ-010 SHALL have ports d_rvalid  output  1  load response pulse; d_rdata  output  DDATA_WIDTH  load data; d_wready  output  1  store-done pulse.
REQ-011 SHALL have ports m_req  output  1; m_we  output  1; m_addr  output  ADDR_WIDTH; m_wdata  output  DDATA_WIDTH; m_wmask  output  8.
REQ-012 SHALL have ports m_gnt  input  1  memory accepted request; m_rvalid  input  1  read data valid; m_rdata  input  DDATA_WIDTH.

Function
REQ-013 SHALL implement FSM IDLE -> REQ -> (WAIT for reads | IDLE for writes) -> IDLE, one transaction outstanding.
REQ-014 SHALL sample requests only in IDLE; winner's address/data/mask/type latched, m_req asserted the following cycle.
REQ-015 SHALL hold m_req and all m_* fields stable from REQ entry until the cycle m_gnt=1 is seen.
REQ-016 SHALL on m_gnt with m_we=1 pulse d_wready for one cycle the next cycle and return to IDLE.
REQ-017 SHALL on m_gnt with m_we=0 enter WAIT; on m_rvalid register data and pulse i_rvalid or d_rvalid one cycle later, then IDLE.
REQ-018 SHALL drive i_rdata = m_rdata[31:0] when latched i_addr[2]=0, else m_rdata[63:32].
REQ-019 SHALL, with fixed priority, grant data over fetch when both request in IDLE.
REQ-020 SHALL treat d_rd and d_wr both high as a store (write wins).
REQ-021 SHALL ignore request deassertion mid-transaction; transaction completes and response still pulses.
REQ-022 SHALL ignore m_rvalid outside WAIT and m_gnt outside REQ.
REQ-023 SHALL require at least one IDLE cycle between transactions; back-to-back throughput is one transaction per (grant + response + 2) cycles.
REQ-024 SHALL hold i_rdata/d_rdata at last captured value between pulses.

Reset
REQ-025 SHALL on rst force IDLE, abandon any in-flight transaction without response, and zero all outputs (m_req, m_we, m_addr, m_wdata, m_wmask, i_rvalid, i_rdata, d_rvalid, d_rdata, d_wready).
REQ-026 SHALL accept new requests the first cycle after rst deasserts.

Configuration
REQ-027 SHALL, when YSYX_22050243_ARB_RR_EN is defined, use round-robin: a one-bit last-grant register (reset to fetch) gives ties to the requester not last granted.
REQ-028 SHALL, when YSYX_22050243_ARB_RR_EN is undefined, use fixed data-over-fetch priority per REQ-019 with no last-grant register.

Structure
REQ-029 SHALL place FSM state enum (IDLE, REQ, WAIT), grant-owner encoding (GNT_I, GNT_D) in shared package ysyx_22050243_arb_pkg.
REQ-030 SHALL isolate winner selection (fixed or round-robin) in sub-module ysyx_22050243_arb_pick.

Verification
REQ-031 Fetch only: i_req=1, i_addr=0x80000004, m_gnt after 2 cycles, m_rdata=0x00000013_DEADBEEF -> m_addr=0x80000004, m_we=0, one i_rvalid pulse, i_rdata=0x00000013.
REQ-032 Store: d_wr=1, d_addr=0x80001000, d_wdata=0x1122334455667788, d_wmask=0x0F -> m_we=1 with same fields held until m_gnt, one d_wready pulse, no i_rvalid/d_rvalid.
REQ-033 Collision: i_req=1 and d_rd=1 same IDLE cycle -> data granted first (fixed); with YSYX_22050243_ARB_RR_EN and last grant=data, fetch granted first.
REQ-034 Stall: m_gnt held 0 for 10 cycles -> m_req and m_addr unchanged all 10 cycles, no response pulses.
REQ-035 Reset in WAIT: rst asserted while awaiting m_rvalid -> next cycle all outputs 0, later m_rvalid produces no response pulse.
REQ-036 Back-to-back: d_rd and i_req held continuously, m_gnt/m_rvalid immediate -> alternating grants under RR, data-only grants under fixed priority, one IDLE cycle between each.
